ccg_vector_sequencer: RTL and testbench

//  Sequencer for a generated combinational circuit-under-test (CUT, 6 in / 18 out gate netlist).

---
 rtl/ccg_vector_sequencer.sv | 153 +++++++++++++++
 tb/tb_ccg_vector_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccg_vector_sequencer.sv
// Exhaustive ascending input sweep for a combinational CUT, streaming (vector, response) pairs over valid/ready.
// Optional feature macro CCG_MISR_EN: compacts accepted responses into a MISR signature on sig.
module ccg_vector_sequencer #(
    parameter int               N_IN          = 6,
    parameter int               N_OUT         = 18,
    parameter int               SETTLE_CYCLES = 2,
    parameter logic [N_OUT-1:0] MISR_POLY     = 18'h00081
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  cut_in,
    input  logic [N_OUT-1:0] cut_out,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic [N_IN-1:0]  cap_vec,
    output logic [N_OUT-1:0] cap_resp,
    output logic [N_OUT-1:0] sig,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    if (SETTLE_CYCLES < 1 || MISR_POLY == '0) begin : g_bad_params
        $error("ccg_vector_sequencer: SETTLE_CYCLES must be >= 1 and MISR_POLY must be nonzero");
    end

    state_t            r_state;
    logic [CNT_W-1:0]  r_settle_cnt;
    logic [N_IN-1:0]   r_cut_in;
    logic              r_busy;
    logic              r_done;
    logic              r_cap_valid;
    logic [N_IN-1:0]   r_cap_vec;
    logic [N_OUT-1:0]  r_cap_resp;

    logic w_start_ok;
    logic w_accept;
    logic w_last_vec;

    // Capture handshake: a pair transfers on a rising edge where cap_valid && cap_ready.
    // Once raised, cap_valid/cap_vec/cap_resp hold until that transfer; cap_ready may toggle freely.
    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_accept   = (r_state == ST_CAPTURE) && r_cap_valid && cap_ready;
    assign w_last_vec = (r_cut_in == {N_IN{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_cut_in     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cap_valid  <= 1'b0;
            r_cap_vec    <= '0;
            r_cap_resp   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cut_in     <= '0;
                        r_settle_cnt <= SETTLE_RELOAD;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Counter reaches 0 exactly SETTLE_CYCLES edges after cut_in last changed.
                    if (r_settle_cnt == '0) begin
                        r_cap_resp  <= cut_out;
                        r_cap_vec   <= r_cut_in;
                        r_cap_valid <= 1'b1;
                        r_state     <= ST_CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (w_accept) begin
                        r_cap_valid <= 1'b0;
                        if (w_last_vec) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_cut_in     <= r_cut_in + 1'b1;
                            r_settle_cnt <= SETTLE_RELOAD;
                            r_state      <= ST_SETTLE;
                        end
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CCG_MISR_EN
    logic [N_OUT-1:0] r_sig;
    logic [N_OUT-1:0] w_sig_next;

    always_comb begin
        w_sig_next = {r_sig[N_OUT-2:0], 1'b0} ^ r_cap_resp;
        if (r_sig[N_OUT-1]) begin
            w_sig_next = w_sig_next ^ MISR_POLY;
        end
    end

    // Signature clears on an accepted start and holds after the sweep for readout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= '0;
        end else if (w_start_ok) begin
            r_sig <= '0;
        end else if (w_accept) begin
            r_sig <= w_sig_next;
        end
    end

    assign sig = r_sig;
`else
    assign sig = '0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign cut_in    = r_cut_in;
    assign cap_valid = r_cap_valid;
    assign cap_vec   = r_cap_vec;
    assign cap_resp  = r_cap_resp;
    assign dbg_state = r_state;

    a_cap_hold: assert property (@(posedge clk) disable iff (rst)
        (cap_valid && !cap_ready) |=> (cap_valid && $stable(cap_vec) && $stable(cap_resp)));

    a_done_not_busy: assert property (@(posedge clk) disable iff (rst) done |-> !busy);

endmodule

// File: tb/tb_ccg_vector_sequencer.sv
// Scoreboard bench for ccg_vector_sequencer: expected pairs queued on start, popped by a monitor on each handshake.
module tb_ccg_vector_sequencer;

    localparam int N_IN   = 6;
    localparam int N_OUT  = 18;
    localparam int SETTLE = 2;
    localparam int NVEC   = 1 << N_IN;
    localparam int PW     = N_IN + N_OUT;
    localparam int SWEEP_CYCLES = NVEC * (SETTLE + 1) + 1;
    localparam logic [N_OUT-1:0] POLY = 18'h00081;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cap_ready;
    logic [N_OUT-1:0] cut_out;
    logic             busy;
    logic             done;
    logic [N_IN-1:0]  cut_in;
    logic             cap_valid;
    logic [N_IN-1:0]  cap_vec;
    logic [N_OUT-1:0] cap_resp;
    logic [N_OUT-1:0] sig;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    ccg_vector_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(SETTLE), .MISR_POLY(POLY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cut_in(cut_in), .cut_out(cut_out), .cap_valid(cap_valid), .cap_ready(cap_ready),
        .cap_vec(cap_vec), .cap_resp(cap_resp), .sig(sig), .dbg_state(dbg_state)
    );

    // ---------------- bench state ----------------
    logic [PW-1:0]    exp_q[$];
    logic [PW-1:0]    exp_pair;
    logic [N_OUT-1:0] exp_sig = '0;
    int chk_cnt   = 0;
    int pass_cnt  = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int exp_done  = 0;
    int done_seen = 0;
    bit cut_mode   = 1'b0;
    bit rand_ready = 1'b0;
    bit timing_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // mode 0: response is the vector zero-extended; mode 1: small gate netlist.
    function automatic logic [N_OUT-1:0] cut_fn(input logic [N_IN-1:0] x, input bit mode);
        if (!mode) return {{(N_OUT-N_IN){1'b0}}, x};
        return {x ^ {x[4:0], x[5]}, x & {x[2:0], x[5:3]}, ~(x | {x[0], x[5:1]})};
    endfunction

    function automatic logic [N_OUT-1:0] misr_step(input logic [N_OUT-1:0] s, input logic [N_OUT-1:0] r);
        return {s[N_OUT-2:0], 1'b0} ^ (s[N_OUT-1] ? POLY : '0) ^ r;
    endfunction

    // CUT with propagation delay: output is corrupt until cut_in has been stable SETTLE cycles.
    logic [N_IN-1:0] last_in = '0;
    int age = 255;
    always @(negedge clk) begin
        if (cut_in !== last_in) age = 1;
        else if (age < 255) age++;
        last_in = cut_in;
        cut_out = (age >= SETTLE) ? cut_fn(cut_in, cut_mode) : ~cut_fn(cut_in, cut_mode);
    end

    always @(negedge clk) begin
        if (rand_ready) cap_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- monitor / scoreboard ----------------
    bit               prev_stall = 1'b0;
    bit               prev_done  = 1'b0;
    logic [N_IN-1:0]  prev_vec;
    logic [N_OUT-1:0] prev_resp;

    always @(negedge clk) begin
        #1;
        if (prev_stall) begin
            check("stall_valid", cap_valid, 1);
            check("stall_vec", cap_vec, prev_vec);
            check("stall_resp", cap_resp, prev_resp);
        end
        prev_stall = cap_valid && !cap_ready && !rst;
        prev_vec   = cap_vec;
        prev_resp  = cap_resp;
        if (cap_valid && cap_ready && !rst) begin
            check("pair_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_pair = exp_q.pop_front();
                check("pair", {cap_vec, cap_resp}, exp_pair);
            end
`ifndef CCG_MISR_EN
            check("sig_zero", sig, 0);
`endif
        end
        if (done) begin
            done_seen++;
            check("done_pulse_width", prev_done, 0);
            check("done_expected", done_seen <= exp_done, 1);
            check("done_queue_drained", exp_q.size(), 0);
            check("done_busy_low", busy, 0);
            check("done_sig", sig, exp_sig);
            if (timing_chk) check("done_latency", cyc - start_cyc, SWEEP_CYCLES);
        end
        prev_done = done;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue_start(input bit accept);
        logic [N_OUT-1:0] s;
        logic [N_OUT-1:0] r;
        logic [N_IN-1:0]  v;
        start = 1'b1;
        if (accept) begin
            s = '0;
            start_cyc = cyc + 1;
            for (int i = 0; i < NVEC; i++) begin
                v = N_IN'(i);
                r = cut_fn(v, cut_mode);
                exp_q.push_back({v, r});
                s = misr_step(s, r);
            end
`ifdef CCG_MISR_EN
            exp_sig = s;
`else
            exp_sig = '0;
`endif
            exp_done++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_seen < exp_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("sweep_done_in_budget", done_seen == exp_done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cut_in"}, cut_in, 0);
        check({tag, "_cap_valid"}, cap_valid, 0);
        check({tag, "_cap_vec"}, cap_vec, 0);
        check({tag, "_cap_resp"}, cap_resp, 0);
        check({tag, "_sig"}, sig, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        cap_ready = 1'b1;

        // Reset for two cycles, then start one cycle after release.
        tick(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(1);

        // Full sweep, ready tied high, identity CUT: ordered pairs and exact latency.
        cut_mode = 1'b0;
        timing_chk = 1'b1;
        issue_start(1'b1);
        check("start_busy", busy, 1);
        check("start_cut_in", cut_in, 0);
        check("start_sig", sig, 0);
        wait_done(SWEEP_CYCLES + 20);

        // Random backpressure with the netlist CUT.
        timing_chk = 1'b0;
        cut_mode = 1'b1;
        rand_ready = 1'b1;
        tick(3);
        issue_start(1'b1);
        wait_done(2000);

        // Mid-sweep reset at vector 17, then a clean restart.
        cut_mode = 1'b0;
        tick(2);
        issue_start(1'b1);
        n = 0;
        while (cut_in !== N_IN'(17) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_vec17", cut_in, 17);
        rst = 1'b1;
        exp_q.delete();
        exp_done--;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midreset");
        tick(20);
        check("abort_no_done", done_seen, exp_done);
        check("abort_idle", busy, 0);
        issue_start(1'b1);
        wait_done(2000);

        // Ignored starts: several while busy, one on the FINISH cycle.
        rand_ready = 1'b0;
        cap_ready = 1'b1;
        cut_mode = 1'b1;
        timing_chk = 1'b1;
        tick(2);
        issue_start(1'b1);
        while (cyc < start_cyc + SWEEP_CYCLES - 1) begin
            start = (cyc == start_cyc + 10 || cyc == start_cyc + 50 || cyc == start_cyc + 100);
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(50);
        tick(20);
        check("ignored_start_idle", busy, 0);
        check("ignored_start_no_pair", cap_valid, 0);
        check("ignored_start_done_count", done_seen, exp_done);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_done_count", done_seen, 4);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
